// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle
// data_valid / frame_err strobes and a held copy of the last good byte.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t           state;
   logic             rx_p0;
   logic             rx_s;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;

   // Synchroniser: rx is asynchronous to clk; only rx_s is used downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_s  <= rx_p0;
      end
   end

   // Frame FSM: rx_busy is registered alongside every state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (!rx_s) begin
                  state   <= START;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt == CNT_HALF) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_cnt] <= rx_s;
                  bit_cnt            <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid stop bit lets a back-to-back start edge be caught.
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     data_out   <= shift_reg;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                     rx_busy    <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               clk_cnt <= '0;
               if (rx_s) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               clk_cnt <= '0;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
